btc_miner_dispatch: RTL and testbench

Job controller and result collector between the Wishbone register block and a parametrised array of mining cores. It launches and aborts jobs on all cores and latches every nonce reported by any core, not only the last one. Results are merged through a round-robin arbiter into a result FIFO, and the block reports job completion and overflow. It replaces the fixed 8-core, last-nonce-wins combine logic of the current miner top.

---
 rtl/btc_miner_dispatch.sv | 228 ++++++++++++++++++++++
 tb/tb_btc_miner_dispatch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btc_miner_dispatch.sv
// Generic FIFO: synchronous push/pop with flush, registered pointers.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: full reported to the writer; push and pop together on a full FIFO are legal.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         flush,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    assign rd_vld = (cnt != '0);
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign pop    = rd_vld && rd_rdy;
    assign push   = wr_vld && (!full || pop);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Mining job controller: launches/aborts cores, collects every found nonce via per-core slots.
// Latency: start -> core_start next cycle; found -> result at head two cycles later.
// Backpressure: res_valid/res_ready; when the FIFO is full slots hold, a repeat find overwrites (overflow).
module btc_miner_dispatch #(
    parameter  int NUM_CORES  = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int CORE_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    oneshot,
    output logic                    core_start,
    output logic                    core_abort,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_found,
    input  logic [32*NUM_CORES-1:0] core_nonce,
    output logic                    busy,
    output logic                    done,
    output logic                    res_valid,
    output logic [31:0]             res_nonce,
    output logic [CORE_W-1:0]       res_core,
    input  logic                    res_ready,
    output logic                    overflow,
    output logic [15:0]             found_count
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, STOP, DRAIN} state_t;

    state_t                state;
    state_t                nxt;
    logic                  done_set;
    logic                  oneshot_q;
    logic                  start_acc;
    logic                  abort_acc;
    logic                  clr_slots;
    logic [NUM_CORES-1:0]  found_acc;
    logic [NUM_CORES-1:0]  slot_vld;
    logic [31:0]           slot_nonce [NUM_CORES];
    logic [CORE_W-1:0]     rr_ptr;
    logic [CORE_W-1:0]     gnt_idx;
    logic                  gnt_any;
    logic [NUM_CORES-1:0]  gnt_oh;
    logic                  can_push;
    logic                  fifo_full;
    logic                  fifo_vld;
    logic [CORE_W+31:0]    fifo_head;
    logic                  pop;
    logic                  overflow_hit;
    logic [5:0]            found_n;
    logic [16:0]           count_sum;

    assign start_acc    = (state == IDLE) && start;
    assign abort_acc    = (state != IDLE) && abort;
    assign clr_slots    = start_acc || abort_acc;
    assign found_acc    = (state != IDLE) ? core_found : '0;
    assign overflow_hit = |(found_acc & slot_vld & ~gnt_oh);
    assign pop          = fifo_vld && res_ready;
    assign can_push     = !fifo_full || pop;

    assign busy       = (state != IDLE);
    assign core_start = (state == LAUNCH);
    assign res_valid  = fifo_vld;
    assign res_nonce  = fifo_vld ? fifo_head[31:0] : '0;
    assign res_core   = fifo_vld ? fifo_head[CORE_W+31:32] : '0;

    always_comb begin
        nxt      = state;
        done_set = 1'b0;
        case (state)
            IDLE:    if (start) nxt = LAUNCH;
            LAUNCH:  nxt = RUN;
            RUN: begin
                if (oneshot_q && (|core_found)) nxt = STOP;
                else if (&core_done)            nxt = DRAIN;
            end
            STOP:    nxt = DRAIN;
            DRAIN: begin
                if (slot_vld == '0) begin
                    nxt      = IDLE;
                    done_set = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
        if (abort_acc) begin
            nxt      = IDLE;
            done_set = 1'b0;
        end
    end

    // Round-robin search starting at rr_ptr; only grants when the FIFO can take the entry.
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = (int'(rr_ptr) + k) % NUM_CORES;
            if (!gnt_any && can_push && slot_vld[j]) begin
                gnt_any = 1'b1;
                gnt_idx = CORE_W'(j);
            end
        end
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        found_n = '0;
        for (int i = 0; i < NUM_CORES; i++) found_n = found_n + 6'(found_acc[i]);
        count_sum = {1'b0, found_count} + 17'(found_n);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            oneshot_q   <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            found_count <= '0;
            core_abort  <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            state      <= nxt;
            core_abort <= abort_acc || ((state == RUN) && (nxt == STOP));
            if (gnt_any) rr_ptr <= CORE_W'((int'(gnt_idx) + 1) % NUM_CORES);
            if (start_acc) begin
                oneshot_q   <= oneshot;
                done        <= 1'b0;
                overflow    <= 1'b0;
                found_count <= '0;
            end else begin
                if (done_set)     done     <= 1'b1;
                if (overflow_hit) overflow <= 1'b1;
                found_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
            end
        end
    end

    // A find on the granted core in the same cycle reloads the slot without loss.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_nonce[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (clr_slots) begin
                    slot_vld[i] <= 1'b0;
                end else if (found_acc[i]) begin
                    slot_vld[i]   <= 1'b1;
                    slot_nonce[i] <= core_nonce[32*i +: 32];
                end else if (gnt_oh[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    fifo #(.W(CORE_W + 32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .flush  (start_acc),
        .wr_vld (gnt_any),
        .wr_dat ({gnt_idx, slot_nonce[gnt_idx]}),
        .full   (fifo_full),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_head),
        .rd_rdy (res_ready)
    );
endmodule

// File: tb/tb_btc_miner_dispatch.sv
// Directed bench for btc_miner_dispatch (8 cores, 4-entry FIFO) with hand-derived expectations.
module tb_btc_miner_dispatch;
    logic         clk = 1'b0;
    logic         arst_n;
    logic         start, abort, oneshot, res_ready;
    logic         core_start, core_abort, busy, done, res_valid, overflow;
    logic [7:0]   core_done, core_found;
    logic [255:0] core_nonce;
    logic [31:0]  res_nonce;
    logic [2:0]   res_core;
    logic [15:0]  found_count;
    int total = 0;
    int bad   = 0;

    btc_miner_dispatch #(.NUM_CORES(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .abort(abort), .oneshot(oneshot),
        .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
        .core_found(core_found), .core_nonce(core_nonce), .busy(busy), .done(done),
        .res_valid(res_valid), .res_nonce(res_nonce), .res_core(res_core),
        .res_ready(res_ready), .overflow(overflow), .found_count(found_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int core, input logic [31:0] nonce);
        chk({tag, "_vld"}, 32'(res_valid), 32'd1);
        chk({tag, "_core"}, 32'(res_core), 32'(core));
        chk({tag, "_nonce"}, res_nonce, nonce);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_nonce"}, res_nonce, 32'd0);
        chk({tag, "_res_core"}, 32'(res_core), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_found_count"}, 32'(found_count), 32'd0);
        chk({tag, "_core_start"}, 32'(core_start), 32'd0);
        chk({tag, "_core_abort"}, 32'(core_abort), 32'd0);
    endtask

    task automatic set_nonces(input logic [31:0] base);
        for (int i = 0; i < 8; i++) core_nonce[32*i +: 32] = base + 32'(i);
    endtask

    // Pulse start in IDLE; returns in the first RUN cycle.
    task automatic launch(input logic os);
        start = 1'b1; oneshot = os;
        tick();
        start = 1'b0; oneshot = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; abort = 1'b0; oneshot = 1'b0; res_ready = 1'b0;
        core_done = '0; core_found = '0; core_nonce = '0;
        #3;
        chk_reset_outputs("rst");
        tick();
        arst_n = 1'b1;
        tick();

        // Single find on core 5, then job completion.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_core_start", 32'(core_start), 32'd1);
        chk("launch_busy", 32'(busy), 32'd1);
        tick();
        chk("run_core_start", 32'(core_start), 32'd0);
        core_nonce[32*5 +: 32] = 32'hA000_1234; core_found = 8'b0010_0000;
        tick();
        core_found = '0;
        chk("t1_res_valid_early", 32'(res_valid), 32'd0);
        tick();
        chk_head("t1_head", 5, 32'hA000_1234);
        chk("t1_count", 32'(found_count), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("t1_popped", 32'(res_valid), 32'd0);
        core_done = 8'hFF;
        tick();
        chk("t1_drain_busy", 32'(busy), 32'd1);
        chk("t1_drain_done", 32'(done), 32'd0);
        tick();
        core_done = '0;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Fresh reset so rr_ptr starts at 0, then simultaneous finds.
        pulse_reset();
        tick();
        launch(1'b0);
        set_nonces(32'hB000_0000);
        res_ready = 1'b1;
        core_found = 8'b0100_1010;
        tick();
        core_found = '0;
        tick();
        chk_head("rr_a", 1, 32'hB000_0001);
        tick();
        chk_head("rr_b", 3, 32'hB000_0003);
        tick();
        chk_head("rr_c", 6, 32'hB000_0006);
        tick();
        chk("rr_empty", 32'(res_valid), 32'd0);
        // rr_ptr is now 7: searching 7,0,1,... finds core 0 before core 3.
        set_nonces(32'hB100_0000);
        core_found = 8'b0000_1001;
        tick();
        core_found = '0;
        tick();
        chk_head("rr_wrap_a", 0, 32'hB100_0000);
        tick();
        chk_head("rr_wrap_b", 3, 32'hB100_0003);
        tick();
        res_ready = 1'b0;

        // Fill the FIFO with cores 0..3, leave core 7 pending, then abort.
        set_nonces(32'hC000_0000);
        core_found = 8'b0000_1111;
        tick();
        core_found = '0;
        repeat (4) tick();
        core_nonce[32*7 +: 32] = 32'hC000_0777; core_found = 8'b1000_0000;
        tick();
        core_found = '0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_core_abort", 32'(core_abort), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_count", 32'(found_count), 32'd10);
        tick();
        chk("ab_core_abort_once", 32'(core_abort), 32'd0);
        chk_head("ab_keep0", 0, 32'hC000_0000);
        res_ready = 1'b1;
        tick();
        chk_head("ab_keep1", 1, 32'hC000_0001);
        tick();
        chk_head("ab_keep2", 2, 32'hC000_0002);
        tick();
        chk_head("ab_keep3", 3, 32'hC000_0003);
        tick();
        chk("ab_slot7_lost", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

        // Overflow: six finds into a 4-deep FIFO, then a repeat on pending core 4.
        pulse_reset();
        tick();
        launch(1'b0);
        set_nonces(32'hD000_0000);
        core_found = 8'b0011_1111;
        tick();
        core_found = '0;
        repeat (4) tick();
        chk("of_none_yet", 32'(overflow), 32'd0);
        chk("of_count6", 32'(found_count), 32'd6);
        chk_head("of_head", 0, 32'hD000_0000);
        core_nonce[32*4 +: 32] = 32'hD000_4444; core_found = 8'b0001_0000;
        tick();
        core_found = '0;
        chk("of_set", 32'(overflow), 32'd1);
        chk("of_count7", 32'(found_count), 32'd7);
        res_ready = 1'b1;
        chk_head("of_d0", 0, 32'hD000_0000);
        tick();
        chk_head("of_d1", 1, 32'hD000_0001);
        tick();
        chk_head("of_d2", 2, 32'hD000_0002);
        tick();
        chk_head("of_d3", 3, 32'hD000_0003);
        tick();
        chk_head("of_d4", 4, 32'hD000_4444);
        tick();
        chk_head("of_d5", 5, 32'hD000_0005);
        tick();
        chk("of_empty", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
        core_done = 8'hFF;
        tick();
        tick();
        core_done = '0;
        chk("of_job_done", 32'(done), 32'd1);

        // Oneshot: first find stops the job with a single abort pulse.
        launch(1'b1);
        chk("os_done_cleared", 32'(done), 32'd0);
        core_nonce[32*2 +: 32] = 32'hE000_0002; core_found = 8'b0000_0100;
        tick();
        core_found = '0;
        chk("os_abort_pulse", 32'(core_abort), 32'd1);
        tick();
        chk("os_abort_once", 32'(core_abort), 32'd0);
        chk("os_busy_drain", 32'(busy), 32'd1);
        tick();
        chk("os_done", 32'(done), 32'd1);
        chk("os_idle", 32'(busy), 32'd0);
        core_nonce[32*2 +: 32] = 32'hE000_9999; core_found = 8'b0000_0100;
        tick();
        core_found = '0;
        chk("os_idle_ignored", 32'(found_count), 32'd1);
        chk_head("os_head", 2, 32'hE000_0002);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("os_empty", 32'(res_valid), 32'd0);

        // Asynchronous reset mid-run with three entries queued.
        launch(1'b0);
        set_nonces(32'hF000_0000);
        core_found = 8'b0000_0111;
        tick();
        core_found = '0;
        repeat (4) tick();
        chk("ar_busy_before", 32'(busy), 32'd1);
        chk_head("ar_head_before", 0, 32'hF000_0000);
        arst_n = 1'b0;
        #1;
        chk_reset_outputs("ar");
        #1;
        arst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
